// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control sequencer: fetch/decode/execute/memory/writeback,
// owning PC, IR, MDR, the retired-instruction counter and the memory handshake.
module lc3_sequencer #(
    parameter logic [15:0] PC_RESET    = 16'h3000,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] mdr,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM1   = 3'd4,
        S_MEM2   = 3'd5,
        S_WB     = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [3:0] OP_LD  = 4'd3;
    localparam logic [3:0] OP_LDI = 4'd4;
    localparam logic [3:0] OP_ST  = 4'd6;
    localparam logic [1:0] SEL_PC  = 2'd0;
    localparam logic [1:0] SEL_EA  = 2'd1;
    localparam logic [1:0] SEL_MDR = 2'd2;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ill_q, ill_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  sel_q, sel_d;

    logic [3:0] opcode;
    logic       in_mem_state;
    logic       timed_out;

    assign opcode       = ir_q[15:12];
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM1) || (state_q == S_MEM2);
    // A ready in the same cycle the limit is reached takes priority over the timeout.
    assign timed_out    = in_mem_state && !mem_ready && (wait_q == MEM_TIMEOUT - 8'd1);

    // NOTE: every register updates with <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= 16'h0000;
            mdr_q     <= 16'h0000;
            cnt_q     <= 16'h0000;
            ill_q     <= 1'b0;
            wait_q    <= 8'd0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            sel_q     <= SEL_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            cnt_q     <= cnt_d;
            ill_q     <= ill_d;
            wait_q    <= wait_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            sel_q     <= sel_d;
        end
    end

    // NOTE: hold-value defaults at the top keep this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    ill_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (opcode <= OP_ST) begin
                    state_d = S_EXEC;
                end else begin
                    ill_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST) state_d = S_MEM1;
                else                                                        state_d = S_WB;
            end
            S_MEM1: begin
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = (opcode == OP_LDI) ? S_MEM2 : S_WB;
                    end
                end else if (timed_out) begin
                    ill_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_MEM2: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_WB;
                end else if (timed_out) begin
                    ill_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = S_FETCH;
            end
            default: ;
        endcase

        // Counter restarts on every state change, so each memory state gets a fresh budget.
        if (state_d != state_q)             wait_d = 8'd0;
        else if (in_mem_state && !mem_ready) wait_d = wait_q + 8'd1;
        else                                 wait_d = wait_q;
    end

    // Memory strobes are computed from the upcoming state and registered, so they
    // are glitch-free and constant for the whole memory state.
    always_comb begin
        mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM1) || (state_d == S_MEM2);
        mem_we_d  = (state_d == S_MEM1) && (opcode == OP_ST);
        unique case (state_d)
            S_MEM1:  sel_d = SEL_EA;
            S_MEM2:  sel_d = SEL_MDR;
            default: sel_d = SEL_PC;
        endcase
        alu_op    = (state_q == S_EXEC) ? {1'b0, ir_q[14:12]} : 4'b1111;
        reg_write = (state_q == S_WB);
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr_sel = sel_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign mdr          = mdr_q;
    assign illegal      = ill_q;
    assign state        = state_q;
    assign instr_count  = cnt_q;

endmodule
